// File: rtl/regfile_scoreboard.sv
// Integer register file with write-to-read bypass, x0 hardwired to zero,
// a per-register busy scoreboard for long-latency producers and a commit counter.
// finish_flag freezes all architectural state while reads stay live.
module regfile_scoreboard #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned NRD    = 2,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned AW    = $clog2(NREG)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                finish_flag,
  input  logic [NRD*AW-1:0]   read_addr,
  output logic [NRD*XLEN-1:0] read_data,
  output logic [NRD-1:0]      read_busy,
  input  logic                write_en,
  input  logic [AW-1:0]       write_addr,
  input  logic [XLEN-1:0]     write_data,
  input  logic                reserve_en,
  input  logic [AW-1:0]       reserve_addr,
  output logic [NREG-1:0]     busy_vec,
  output logic [31:0]         write_count
);

  localparam int unsigned CW = 32;

  // Elaboration guard: addresses must cover the register space exactly.
  if (NREG < 2 || (NREG & (NREG - 1)) != 0) begin : g_bad_nreg
    $error("regfile_scoreboard: NREG must be a power of two >= 2");
  end
  if (NRD < 1 || NRD > 4) begin : g_bad_nrd
    $error("regfile_scoreboard: NRD must be in 1..4");
  end

  logic [XLEN-1:0] rf_q [NREG];
  logic [XLEN-1:0] rf_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [CW-1:0]   write_count_q, write_count_d;

  logic wr_ok;
  logic rsv_ok;

  // Effective strobes: finished programs and x0 never change state.
  always_comb begin
    wr_ok  = write_en   & ~finish_flag & (write_addr   != '0);
    rsv_ok = reserve_en & ~finish_flag & (reserve_addr != '0);
  end

  // Next-state for registers, scoreboard and commit counter.
  always_comb begin
    for (int i = 0; i < int'(NREG); i++) begin
      rf_d[i] = rf_q[i];
    end
    busy_d        = busy_q;
    write_count_d = write_count_q;
    if (wr_ok) begin
      rf_d[write_addr]   = write_data;
      busy_d[write_addr] = 1'b0;
      write_count_d      = write_count_q + CW'(1);
    end
    // Reserve is applied last so it wins over a same-cycle write.
    if (rsv_ok) begin
      busy_d[reserve_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NREG); i++) begin
        rf_q[i] <= '0;
      end
      busy_q        <= '0;
      write_count_q <= '0;
    end else begin
      for (int i = 0; i < int'(NREG); i++) begin
        rf_q[i] <= rf_d[i];
      end
      busy_q        <= busy_d;
      write_count_q <= write_count_d;
    end
  end

  // Independent combinational read ports; busy is never bypassed.
  for (genvar k = 0; k < int'(NRD); k++) begin : g_rd
    logic [AW-1:0] addr;
    assign addr = read_addr[k*AW +: AW];
    assign read_data[k*XLEN +: XLEN] =
        (addr == '0)                                    ? '0         :
        ((BYPASS != 0) && wr_ok && (addr == write_addr)) ? write_data :
                                                          rf_q[addr];
    assign read_busy[k] = busy_q[addr];
  end

  assign busy_vec    = busy_q;
  assign write_count = write_count_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: default instance (XLEN=32, NREG=32, NRD=2, BYPASS=1) and a wide
// instance (XLEN=64, NREG=16, NRD=3, BYPASS=0) sharing clock and reset.
module tb_regfile_scoreboard;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // Instance A signals
  logic        a_fin, a_we, a_re;
  logic [9:0]  a_raddr;
  logic [63:0] a_rdata;
  logic [1:0]  a_rbusy;
  logic [4:0]  a_waddr, a_rsvaddr;
  logic [31:0] a_wdata, a_busy, a_cnt;

  // Instance B signals
  logic         b_fin, b_we, b_re;
  logic [11:0]  b_raddr;
  logic [191:0] b_rdata;
  logic [2:0]   b_rbusy;
  logic [3:0]   b_waddr, b_rsvaddr;
  logic [63:0]  b_wdata;
  logic [15:0]  b_busy;
  logic [31:0]  b_cnt;

  int errors = 0;
  int checks = 0;

  regfile_scoreboard dut_a (
    .clock(clock), .reset(reset), .finish_flag(a_fin),
    .read_addr(a_raddr), .read_data(a_rdata), .read_busy(a_rbusy),
    .write_en(a_we), .write_addr(a_waddr), .write_data(a_wdata),
    .reserve_en(a_re), .reserve_addr(a_rsvaddr),
    .busy_vec(a_busy), .write_count(a_cnt)
  );

  regfile_scoreboard #(.XLEN(64), .NREG(16), .NRD(3), .BYPASS(0)) dut_b (
    .clock(clock), .reset(reset), .finish_flag(b_fin),
    .read_addr(b_raddr), .read_data(b_rdata), .read_busy(b_rbusy),
    .write_en(b_we), .write_addr(b_waddr), .write_data(b_wdata),
    .reserve_en(b_re), .reserve_addr(b_rsvaddr),
    .busy_vec(b_busy), .write_count(b_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and samples happen away from it.
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  initial begin
    reset = 1'b1;
    a_fin = 0; a_we = 0; a_re = 0; a_raddr = '0; a_waddr = '0; a_wdata = '0; a_rsvaddr = '0;
    b_fin = 0; b_we = 0; b_re = 0; b_raddr = '0; b_waddr = '0; b_wdata = '0; b_rsvaddr = '0;
    #2;
    check("rst_cnt", 64'(a_cnt), 64'd0);
    check("rst_busy", 64'(a_busy), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // Write x3 with both ports reading x3: bypass gives new value in the same cycle
    a_we = 1; a_waddr = 5'd3; a_wdata = 32'hDEADBEEF; a_raddr = {5'd3, 5'd3};
    #1;
    check("byp_p0", 64'(a_rdata[31:0]), 64'hDEADBEEF);
    check("byp_p1", 64'(a_rdata[63:32]), 64'hDEADBEEF);
    step();
    a_we = 0;
    #1;
    check("x3_p0", 64'(a_rdata[31:0]), 64'hDEADBEEF);
    check("cnt1", 64'(a_cnt), 64'd1);

    // Write to x0 is dropped and not counted
    a_we = 1; a_waddr = 5'd0; a_wdata = 32'h1234; a_raddr = {5'd0, 5'd0};
    #1;
    check("x0_byp", 64'(a_rdata[31:0]), 64'd0);
    step();
    a_we = 0;
    #1;
    check("x0_rd", 64'(a_rdata[63:32]), 64'd0);
    check("x0_cnt", 64'(a_cnt), 64'd1);
    check("x0_busy", 64'(a_busy[0]), 64'd0);

    // Reserve x7, then clear it with a write
    a_re = 1; a_rsvaddr = 5'd7; a_raddr = {5'd3, 5'd7};
    step();
    a_re = 0;
    #1;
    check("rsv7_vec", 64'(a_busy), 64'h80);
    check("rsv7_rbusy", 64'(a_rbusy), 64'b01);
    a_we = 1; a_waddr = 5'd7; a_wdata = 32'd9;
    #1;
    check("rbusy_nobyp", 64'(a_rbusy[0]), 64'd1);
    step();
    a_we = 0;
    #1;
    check("wr7_vec", 64'(a_busy), 64'h0);
    check("wr7_data", 64'(a_rdata[31:0]), 64'd9);
    check("cnt2", 64'(a_cnt), 64'd2);

    // Same-cycle reserve and write of x7: reserve wins, data still lands
    a_we = 1; a_waddr = 5'd7; a_wdata = 32'h55; a_re = 1; a_rsvaddr = 5'd7;
    step();
    a_we = 0; a_re = 0;
    #1;
    check("rw7_busy", 64'(a_busy[7]), 64'd1);
    check("rw7_data", 64'(a_rdata[31:0]), 64'h55);
    check("cnt3", 64'(a_cnt), 64'd3);

    // finish_flag freezes writes, reserves and counting; bypass suppressed
    a_fin = 1; a_we = 1; a_waddr = 5'd4; a_wdata = 32'd99; a_re = 1; a_rsvaddr = 5'd4;
    a_raddr = {5'd3, 5'd4};
    #1;
    check("fin_nobyp", 64'(a_rdata[31:0]), 64'd0);
    step();
    #1;
    check("fin_x4", 64'(a_rdata[31:0]), 64'd0);
    check("fin_live", 64'(a_rdata[63:32]), 64'hDEADBEEF);
    check("fin_busy4", 64'(a_busy[4]), 64'd0);
    check("fin_cnt", 64'(a_cnt), 64'd3);
    a_fin = 0; a_we = 0; a_re = 0;

    // Write x5=7 then reserve x9, then reset mid-cycle with a write in flight
    a_we = 1; a_waddr = 5'd5; a_wdata = 32'd7; a_re = 1; a_rsvaddr = 5'd9;
    step();
    a_re = 0; a_wdata = 32'hAA; a_raddr = {5'd5, 5'd6};
    #1;
    check("pre_rst_cnt", 64'(a_cnt), 64'd4);
    check("pre_rst_busy", 64'(a_busy), 64'h280);
    a_we = 0;
    reset = 1'b1;
    #1;
    check("mid_rst_x5", 64'(a_rdata[31:0]), 64'd0);
    check("mid_rst_busy", 64'(a_busy), 64'd0);
    check("mid_rst_cnt", 64'(a_cnt), 64'd0);
    a_we = 1;
    step();
    a_we = 0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("post_rst_x5", 64'(a_rdata[31:0]), 64'd0);
    check("post_rst_cnt", 64'(a_cnt), 64'd0);

    // Counter wrap from all-ones
    @(negedge clock);
    force dut_a.write_count_q = 32'hFFFFFFFF;
    #1;
    release dut_a.write_count_q;
    #1;
    check("wrap_pre", 64'(a_cnt), 64'hFFFFFFFF);
    a_we = 1; a_waddr = 5'd1; a_wdata = 32'd1;
    step();
    a_we = 0;
    #1;
    check("wrap_cnt", 64'(a_cnt), 64'd0);

    // Wide instance, no bypass: old value this cycle, new value next cycle
    b_we = 1; b_waddr = 4'd3; b_wdata = 64'hDEADBEEF; b_raddr = {4'd0, 4'd3, 4'd3};
    #1;
    check("b_nobyp_p0", b_rdata[63:0], 64'd0);
    check("b_nobyp_p1", b_rdata[127:64], 64'd0);
    step();
    b_we = 0;
    #1;
    check("b_new_p0", b_rdata[63:0], 64'hDEADBEEF);
    check("b_new_p1", b_rdata[127:64], 64'hDEADBEEF);
    check("b_x0_p2", b_rdata[191:128], 64'd0);

    b_we = 1; b_waddr = 4'd1; b_wdata = 64'h1111_2222_3333_4444;
    step();
    b_waddr = 4'd2; b_wdata = 64'h5555_6666_7777_8888;
    step();
    b_waddr = 4'd15; b_wdata = 64'hFEDC_BA98_7654_3210;
    step();
    b_we = 0; b_raddr = {4'd15, 4'd2, 4'd1};
    #1;
    check("b_p0", b_rdata[63:0], 64'h1111_2222_3333_4444);
    check("b_p1", b_rdata[127:64], 64'h5555_6666_7777_8888);
    check("b_p2", b_rdata[191:128], 64'hFEDC_BA98_7654_3210);
    check("b_cnt", 64'(b_cnt), 64'd4);

    b_re = 1; b_rsvaddr = 4'd2;
    step();
    b_re = 0;
    #1;
    check("b_rbusy", 64'(b_rbusy), 64'b010);
    check("b_busyvec", 64'(b_busy), 64'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
